// File: rtl/mips_cpu_dmem_bridge.sv
// ---------------------------------------------------------------------------
// mips_cpu_dmem_bridge
//   Data-memory access stage between the CPU datapath data port and a
//   waitrequest-handshaked, word-addressed bus. A single-cycle datapath
//   load/store is turned into a bus transaction with byte enables and
//   lane-replicated write data. The stall output gates the datapath
//   clk_enable until the access completes. Load data is returned
//   right-justified to the addressed lane; sign/zero extension is left to the
//   datapath's load selector.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   req_read/req_write   datapath load/store request (level, held while stall)
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_address          byte address
//   req_writedata        right-justified store data
//   req_readdata         right-justified load data, valid in DONE
//   stall                datapath must hold while 1
//   err / err_sticky     one-cycle error pulse / sticky error flag
//   bus_*                word-addressed master port with waitrequest
// ---------------------------------------------------------------------------
module mips_cpu_dmem_bridge #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_address,
   input  logic [31:0] req_writedata,
   output logic [31:0] req_readdata,
   output logic        stall,
   output logic        err,
   output logic        err_sticky,
   output logic [31:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [3:0]  bus_byteenable,
   output logic [31:0] bus_writedata,
   input  logic        bus_waitrequest,
   input  logic [31:0] bus_readdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

   state_t               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [1:0]           addr_lo_q, addr_lo_d;
   logic [1:0]           size_q, size_d;
   logic                 is_write_q, is_write_d;
   logic [3:0]           be_q, be_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 err_done_q, err_done_d;
   logic                 sticky_q, sticky_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

   // request decode
   logic        req_any, req_valid, req_illegal, size_align_ok;
   logic [3:0]  be_new;
   logic [31:0] wd_new;
   logic [31:0] rd_shift, rd_steer;
   logic [TIMEOUT_W-1:0] wdog_inc;
   logic        timeout_hit;

   always_comb begin
      size_align_ok = 1'b0;
      be_new        = 4'b0000;
      wd_new        = req_writedata;
      case (req_size)
         2'b00: begin
            size_align_ok = 1'b1;
            be_new        = 4'b0001 << req_address[1:0];
            wd_new        = {4{req_writedata[7:0]}};
         end
         2'b01: begin
            size_align_ok = ~req_address[0];
            be_new        = req_address[1] ? 4'b1100 : 4'b0011;
            wd_new        = {2{req_writedata[15:0]}};
         end
         2'b10: begin
            size_align_ok = (req_address[1:0] == 2'b00);
            be_new        = 4'b1111;
         end
         default: size_align_ok = 1'b0;
      endcase
   end

   assign req_any     = req_read | req_write;
   assign req_valid   = (req_read ^ req_write) & size_align_ok;
   assign req_illegal = req_any & ~req_valid;

   // right-justify the addressed lane of the returned word
   assign rd_shift = bus_readdata >> {addr_lo_q, 3'b000};
   always_comb begin
      case (size_q)
         2'b00:   rd_steer = {24'd0, rd_shift[7:0]};
         2'b01:   rd_steer = {16'd0, rd_shift[15:0]};
         default: rd_steer = bus_readdata;
      endcase
   end

   // the watchdog fires on the wait cycle that brings the count to the limit
   assign wdog_inc    = wdog_q + 1'b1;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_inc == TO_LIMIT);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      addr_lo_d  = addr_lo_q;
      size_d     = size_q;
      is_write_d = is_write_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_done_d = 1'b0;
      sticky_d   = sticky_q;
      wdog_d     = wdog_q;
      case (state_q)
         S_IDLE: begin
            wdog_d = '0;
            if (req_valid) begin
               state_d    = S_ACCESS;
               addr_d     = {req_address[31:2], 2'b00};
               addr_lo_d  = req_address[1:0];
               size_d     = req_size;
               is_write_d = req_write;
               be_d       = be_new;
               wdata_d    = wd_new;
            end else if (req_illegal) begin
               sticky_d = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!bus_waitrequest) begin
               rdata_d = is_write_q ? 32'd0 : rd_steer;
               state_d = S_DONE;
               wdog_d  = '0;
            end else if (timeout_hit) begin
               rdata_d    = 32'd0;
               err_done_d = 1'b1;
               sticky_d   = 1'b1;
               state_d    = S_DONE;
               wdog_d     = '0;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'd0;
         addr_lo_q  <= 2'b00;
         size_q     <= 2'b00;
         is_write_q <= 1'b0;
         be_q       <= 4'b0000;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         err_done_q <= 1'b0;
         sticky_q   <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         addr_lo_q  <= addr_lo_d;
         size_q     <= size_d;
         is_write_q <= is_write_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_done_q <= err_done_d;
         sticky_q   <= sticky_d;
         wdog_q     <= wdog_d;
      end
   end

   // the IDLE-cycle stall/err come straight from the request, so they are
   // also qualified by reset to keep every output low while reset is held
   assign stall          = reset & (((state_q == S_IDLE) & req_valid) | (state_q == S_ACCESS));
   assign err            = reset & (((state_q == S_IDLE) & req_illegal) | err_done_q);
   assign err_sticky     = sticky_q;
   assign bus_read       = (state_q == S_ACCESS) & ~is_write_q;
   assign bus_write      = (state_q == S_ACCESS) & is_write_q;
   assign bus_address    = addr_q;
   assign bus_byteenable = be_q;
   assign bus_writedata  = wdata_q;
   assign req_readdata   = (state_q == S_DONE) ? rdata_q : 32'd0;

endmodule

// File: doc/mips_cpu_dmem_bridge.md
Name: mips_cpu_dmem_bridge

Overview:
Data-memory access stage directly downstream of the CPU datapath's data port (ALU address / store data out, load word back into the load selector). Converts single-cycle datapath load/store requests into a waitrequest-handshaked, word-addressed bus transaction with byte enables and lane-steered write data. Drives a stall that the top level uses to gate the datapath clk_enable. Returns read data right-justified to the loaded lane; sign/zero extension stays in the load selector.

Parameters:
TIMEOUT_CYCLES, 0, max ACCESS cycles with waitrequest high before abort; 0 = watchdog disabled
TIMEOUT_W, 8, width of watchdog counter; requires TIMEOUT_CYCLES < 2**TIMEOUT_W

Ports:
clk  in  1  system clock, all state rises on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_read  in  1  datapath load request, level, held while stall=1
req_write  in  1  datapath store request, level, held while stall=1
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_address  in  32  byte address from ALU
req_writedata  in  32  store data, right-justified
req_readdata  out  32  load data, right-justified; valid in DONE
stall  out  1  1 = datapath must hold (clk_enable low)
err  out  1  one-cycle pulse on rejected or aborted access
err_sticky  out  1  set by any err pulse, cleared only by reset
bus_address  out  32  word-aligned address {req_address[31:2],2'b00}
bus_read  out  1  bus read strobe
bus_write  out  1  bus write strobe
bus_byteenable  out  4  active lanes
bus_writedata  out  32  lane-replicated store data
bus_waitrequest  in  1  slave not ready; hold request stable
bus_readdata  in  32  slave read word, valid when waitrequest=0 during read

Behaviour:
- Reset (reset=0, immediate): state=IDLE; all outputs 0, including stall, bus strobes, req_readdata, err, err_sticky; watchdog=0.
- States: IDLE, ACCESS, DONE.
- IDLE: valid request (exactly one of req_read/req_write, legal size, aligned) -> stall=1 combinationally; register address/byteenable/writedata/direction; next ACCESS. No request -> stall=0, stay.
- Illegal request (read&write both 1, size=11, half with addr[0]=1, word with addr[1:0]!=0): err=1 for that cycle, err_sticky set, stall=0, no bus cycle, stay IDLE; the instruction retires with req_readdata=0.
- ACCESS: stall=1; bus_read or bus_write=1 with registered fields, stable while bus_waitrequest=1. On waitrequest=0: capture bus_readdata (reads), next DONE. Watchdog increments each waitrequest=1 cycle; if TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES: drop strobe, err pulse, err_sticky set, captured data=0, next DONE.
- DONE: stall=0, strobes 0, req_readdata valid for this cycle (datapath retires); never accepts a new request; next IDLE unconditionally. Watchdog cleared.
- Minimum latency: request in cycle t -> stall high t, t+1 -> DONE t+2 (each waitrequest cycle adds one).
- Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
- Write data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
- Read data: captured word >> (8*addr[1:0]) for byte/half, upper bits zeroed (byte keeps [7:0], half keeps [15:0]); word unchanged.
- Inputs sampled in IDLE only; changes during ACCESS are ignored.
- Reset mid-ACCESS: strobes drop asynchronously, no completion, state IDLE.

Test Plan:
- Word load addr 0x0000_1004, waitrequest=0, bus_readdata=0xDEADBEEF -> bus_address 0x1004, byteenable 1111, stall 2 cycles, req_readdata 0xDEADBEEF in DONE.
- Byte store addr 0x0000_2003, wd=0x000000A5, waitrequest high 3 cycles -> byteenable 1000, bus_writedata 0xA5A5A5A5 stable 4 ACCESS cycles, stall 5 cycles total.
- Half load addr 0x0000_0102, bus_readdata 0x8001_7FFF -> byteenable 1100, req_readdata 0x0000_8001.
- Word load addr 0x0000_0006 -> err pulse 1 cycle, err_sticky=1, no bus_read, stall stays 0; same with read&write both 1.
- TIMEOUT_CYCLES=4, waitrequest stuck 1 -> strobe for 4 cycles, then err pulse, DONE with req_readdata 0, back to IDLE.
- reset driven 0 mid-ACCESS -> bus_read, stall, err_sticky 0 same cycle; after release, new word store completes normally.
